// File: rtl/rib_arb.sv
// rib_arb: three-master, four-slave bus arbiter. Masters are granted by fixed
// priority (m0 > m1 > m2). Each transaction is latched at grant, forwarded to
// the slave selected by addr[29:28], and closed by a single-cycle ack. An ack
// timeout, or an address outside the slave window, closes the transaction with
// zero data and an error pulse.
module rib_arb #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   m_req_i,
    input  logic [2:0]   m_we_i,
    input  logic [95:0]  m_addr_i,
    input  logic [95:0]  m_data_i,
    output logic [31:0]  m_data_o,
    output logic [2:0]   m_ack_o,
    output logic [3:0]   s_req_o,
    output logic         s_we_o,
    output logic [31:0]  s_addr_o,
    output logic [31:0]  s_data_o,
    input  logic [127:0] s_data_i,
    input  logic [3:0]   s_ack_i,
    output logic         hold_flag_o,
    output logic         timeout_err_o
);

    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       id_q, id_d;
    logic [1:0]       sel_q, sel_d;
    logic             we_q, we_d;
    logic [DW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    m_data_q, m_data_d;
    logic [2:0]       m_ack_q, m_ack_d;
    logic [3:0]       s_req_q, s_req_d;
    logic             err_q, err_d;

    logic [1:0]       gnt_id;
    logic [DW-1:0]    gnt_addr;

    // Fixed-priority grant and selection of the winning master's address
    always_comb begin
        gnt_id = 2'd2;
        if (m_req_i[0]) begin
            gnt_id = 2'd0;
        end else if (m_req_i[1]) begin
            gnt_id = 2'd1;
        end
        gnt_addr = m_addr_i[{gnt_id, 5'd0} +: DW];
    end

    // Next-state and next-output logic for the transaction FSM
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        sel_d    = sel_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        m_data_d = m_data_q;
        m_ack_d  = 3'b000;
        s_req_d  = 4'b0000;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m_req_i != 3'b000) begin
                    id_d    = gnt_id;
                    we_d    = m_we_i[gnt_id];
                    addr_d  = {4'h0, gnt_addr[27:0]};
                    wdata_d = m_data_i[{gnt_id, 5'd0} +: DW];
                    sel_d   = gnt_addr[29:28];
                    cnt_d   = '0;
                    if (gnt_addr[31:30] != 2'b00) begin
                        // Outside the slave window: answer immediately with an error
                        state_d  = ST_RESP;
                        m_ack_d  = 3'b001 << gnt_id;
                        m_data_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        s_req_d = 4'b0001 << gnt_addr[29:28];
                    end
                end
            end
            ST_REQ: begin
                if (s_ack_i[sel_q]) begin
                    state_d  = ST_RESP;
                    m_ack_d  = 3'b001 << id_q;
                    m_data_d = we_q ? '0 : s_data_i[{sel_q, 5'd0} +: DW];
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d  = ST_RESP;
                    m_ack_d  = 3'b001 << id_q;
                    m_data_d = '0;
                    err_d    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    s_req_d = s_req_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            id_q     <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            m_data_q <= '0;
            m_ack_q  <= '0;
            s_req_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            m_data_q <= m_data_d;
            m_ack_q  <= m_ack_d;
            s_req_q  <= s_req_d;
            err_q    <= err_d;
        end
    end

    assign m_data_o      = m_data_q;
    assign m_ack_o       = m_ack_q;
    assign s_req_o       = s_req_q;
    assign s_we_o        = we_q;
    assign s_addr_o      = addr_q;
    assign s_data_o      = wdata_q;
    assign timeout_err_o = err_q;

    // Stall the core while its data or fetch port waits for completion
    assign hold_flag_o = (m_req_i[1] & ~m_ack_q[1]) | (m_req_i[2] & ~m_ack_q[2]);

endmodule
